app_fifo_loopback: RTL and testbench

- Parametrised successor to the demo loopback application. Sits between the usb_cdc application-side handshake and user logic, on the same application clock.
- Buffers bytes received from the host (OUT direction) in a DEPTH-entry FIFO. Returns them to the host (IN direction) through a registered output stage.
- A run-time mode applies a selectable transform, or replaces the echo path with a byte-sequence generator.

---
 rtl/app_pkg.sv | 32 +++
 rtl/app_sync_fifo.sv | 65 ++++++
 rtl/app_fifo_loopback.sv | 149 ++++++++++++++
 tb/tb_app_fifo_loopback.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/app_pkg.sv
// app_pkg: shared mode encodings, ASCII constants and the byte transform
// used by the FIFO loopback application.
package app_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO  = 2'b00,
        MODE_UPPER = 2'b01,
        MODE_LOWER = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;
    localparam logic [7:0] LOWER_A     = 8'h61;
    localparam logic [7:0] LOWER_Z     = 8'h7A;
    localparam logic [7:0] UPPER_A     = 8'h41;
    localparam logic [7:0] UPPER_Z     = 8'h5A;

    // Case folding applied to a FIFO byte on its way to the output stage.
    function automatic logic [7:0] apply_transform(input mode_e mode, input logic [7:0] b);
        logic [7:0] r;
        r = b;
        case (mode)
            MODE_UPPER: if (b >= LOWER_A && b <= LOWER_Z) r = b - CASE_OFFSET;
            MODE_LOWER: if (b >= UPPER_A && b <= UPPER_Z) r = b + CASE_OFFSET;
            default:    r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/app_sync_fifo.sv
// app_sync_fifo: DEPTH x 8 synchronous FIFO with show-ahead head byte,
// synchronous flush and full/empty/level status. Async active-low reset
// clears pointers and level; storage is left unreset.
module app_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [7:0]       wr_data,
    input  logic             pop,
    output logic [7:0]       rd_data,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == CNT_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    // Head byte is visible without a pop so the output stage can load and pop on one edge.
    assign rd_data = mem[rd_ptr_reg];

    // Storage write; a flushed cycle writes nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + CNT_W'(1);
                2'b01:   level_reg <= level_reg - CNT_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/app_fifo_loopback.sv
// app_fifo_loopback: buffers host OUT bytes in a FIFO and returns them on
// the IN side through a registered output stage, optionally case-folded,
// or streams a free-running byte counter in COUNT mode.
// Build option: APP_CRLF_EN inserts an LF after every CR returned to the host.
module app_fifo_loopback
    import app_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [7:0]       out_data_i,
    input  logic             out_valid_i,
    output logic             out_ready_o,
    output logic [7:0]       in_data_o,
    output logic             in_valid_o,
    input  logic             in_ready_i,
    input  logic [1:0]       mode_i,
    output logic [CNT_W-1:0] level_o
);

    mode_e            mode_reg;
    logic             rdy_en_reg;
    logic             in_valid_reg, in_valid_next;
    logic [7:0]       in_data_reg, in_data_next;
    logic             src_gen_reg, src_gen_next;
    logic [7:0]       gen_reg, gen_next;

    logic             out_free;
    logic             in_xfer;
    logic             count_active;
    logic             count_req;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             lf_now;

    assign count_active = (mode_reg == MODE_COUNT);
    assign count_req    = (mode_e'(mode_i) == MODE_COUNT);
    assign out_free     = !in_valid_reg || in_ready_i;
    assign in_xfer      = in_valid_reg && in_ready_i;

    // Ready is held low for the first cycle after reset release via rdy_en_reg.
    assign out_ready_o  = rdy_en_reg && (count_active || !fifo_full);
    assign fifo_push    = out_valid_i && out_ready_o && !count_active;
    // Cleared on the entry edge and kept clear while generating.
    assign fifo_flush   = count_active || (out_free && count_req);

    assign in_valid_o   = in_valid_reg;
    assign in_data_o    = in_data_reg;

    app_sync_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (rstn_i),
        .push    (fifo_push),
        .wr_data (out_data_i),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .flush   (fifo_flush),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level_o)
    );

`ifdef APP_CRLF_EN
    logic lf_pending_reg;
    logic cr_accept;
    logic lf_take;

    // A returned CR (never a generated byte) requests an LF on the same edge.
    assign cr_accept = in_xfer && !src_gen_reg && (in_data_reg == ASCII_CR);
    assign lf_now    = lf_pending_reg || cr_accept;
    assign lf_take   = out_free && !count_active && !count_req && lf_now;

    // Pending-LF flag survives only when the request could not be served yet.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lf_pending_reg <= 1'b0;
        end else if (count_active || (out_free && count_req)) begin
            lf_pending_reg <= 1'b0;
        end else begin
            lf_pending_reg <= lf_now && !lf_take;
        end
    end
`else
    assign lf_now = 1'b0;
`endif

    // Output-stage load selection: generator, inserted LF, or transformed FIFO head.
    always_comb begin
        in_valid_next = in_valid_reg;
        in_data_next  = in_data_reg;
        src_gen_next  = src_gen_reg;
        fifo_pop      = 1'b0;
        gen_next      = gen_reg;
        if (in_xfer && src_gen_reg) begin
            gen_next = gen_reg + 8'd1;
        end
        if (out_free) begin
            in_valid_next = 1'b0;
            if (count_active && count_req) begin
                in_valid_next = 1'b1;
                in_data_next  = gen_next;
                src_gen_next  = 1'b1;
            end else if (!count_active && !count_req) begin
                // Mode transitions spend one idle cycle so no stale byte crosses over.
                if (lf_now) begin
                    in_valid_next = 1'b1;
                    in_data_next  = ASCII_LF;
                    src_gen_next  = 1'b0;
                end else if (!fifo_empty) begin
                    in_valid_next = 1'b1;
                    in_data_next  = apply_transform(mode_reg, fifo_head);
                    src_gen_next  = 1'b0;
                    fifo_pop      = 1'b1;
                end
            end
        end
    end

    // State registers; mode only changes while the output stage is free.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_reg     <= MODE_ECHO;
            rdy_en_reg   <= 1'b0;
            in_valid_reg <= 1'b0;
            in_data_reg  <= 8'h00;
            src_gen_reg  <= 1'b0;
            gen_reg      <= 8'h00;
        end else begin
            rdy_en_reg   <= 1'b1;
            in_valid_reg <= in_valid_next;
            in_data_reg  <= in_data_next;
            src_gen_reg  <= src_gen_next;
            gen_reg      <= gen_next;
            if (out_free) begin
                mode_reg <= mode_e'(mode_i);
            end
        end
    end

endmodule

// File: tb/tb_app_fifo_loopback.sv
// tb_app_fifo_loopback: directed vectors for app_fifo_loopback with
// hand-computed expected IN byte streams. Honors APP_CRLF_EN if defined.
module tb_app_fifo_loopback;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rstn_i;
    logic [7:0]       out_data_i;
    logic             out_valid_i;
    logic             out_ready_o;
    logic [7:0]       in_data_o;
    logic             in_valid_o;
    logic             in_ready_i;
    logic [1:0]       mode_i;
    logic [CNT_W-1:0] level_o;

    int total = 0;
    int bad = 0;
    int hold_bad = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic       prev_wait = 1'b0;
    logic [7:0] prev_data = 8'h00;

    app_fifo_loopback #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .out_data_i  (out_data_i),
        .out_valid_i (out_valid_i),
        .out_ready_o (out_ready_o),
        .in_data_o   (in_data_o),
        .in_valid_o  (in_valid_o),
        .in_ready_i  (in_ready_i),
        .mode_i      (mode_i),
        .level_o     (level_o)
    );

    always #5 clk = ~clk;

    // IN-side monitor: a byte seen valid&&ready at negedge transfers on the next posedge.
    always @(negedge clk) begin
        if (rstn_i && in_valid_o && in_ready_i) begin
            rx_q.push_back(in_data_o);
            $display("in xfer data=%02h mode=%0d level=%0d", in_data_o, mode_i, level_o);
        end
    end

    // Hold monitor: a stalled byte must stay valid and unchanged.
    always @(negedge clk) begin
        if (rstn_i && prev_wait && (!in_valid_o || in_data_o != prev_data)) hold_bad++;
        prev_wait = rstn_i && in_valid_o && !in_ready_i;
        prev_data = in_data_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        int t = 0;
        out_data_i  = b;
        out_valid_i = 1'b1;
        while (!out_ready_o && t < 100) begin
            step(1);
            t++;
        end
        check("push_ready", out_ready_o, 1);
        step(1);
        out_valid_i = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rx_q.size() < n && t < 400) begin
            step(1);
            t++;
        end
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check(tag, rx_q[i], exp_q[i]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i      = 1'b1;
        out_valid_i = 1'b0;
        out_data_i  = 8'h00;
        in_ready_i  = 1'b1;
        mode_i      = 2'b00;
        #1 rstn_i = 1'b0;
        #2;
        check("rst_out_ready", out_ready_o, 0);
        check("rst_in_valid", in_valid_o, 0);
        check("rst_in_data", in_data_o, 8'h00);
        check("rst_level", level_o, 0);
        #9 rstn_i = 1'b1;
        #1;
        check("rdy_before_edge", out_ready_o, 0);
        step(1);
        check("rdy_after_edge", out_ready_o, 1);

        // ECHO with first-byte latency
        push(8'h41);
        check("lat_not_yet", in_valid_o, 0);
        step(1);
        check("lat_valid", in_valid_o, 1);
        check("lat_data", in_data_o, 8'h41);
        push(8'h62);
        push(8'h0D);
        exp_q = '{8'h41, 8'h62, 8'h0D};
`ifdef APP_CRLF_EN
        exp_q.push_back(8'h0A);
`endif
        wait_rx(exp_q.size());
        step(3);
        check("echo_level", level_o, 0);
        check_rx("echo");

        // UPPER then LOWER
        mode_i = 2'b01;
        step(2);
        push(8'h61); push(8'h7A); push(8'h7B); push(8'h31);
        exp_q = '{8'h41, 8'h5A, 8'h7B, 8'h31};
        wait_rx(4);
        step(3);
        check_rx("upper");
        mode_i = 2'b10;
        step(2);
        push(8'h41); push(8'h5A); push(8'h5B);
        exp_q = '{8'h61, 8'h7A, 8'h5B};
        wait_rx(3);
        step(3);
        check_rx("lower");

        // Back-pressure: one byte parks in the output stage, 16 fill the FIFO.
        mode_i = 2'b00;
        step(2);
        in_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
        check("full_level", level_o, 16);
        out_data_i  = 8'hEE;
        out_valid_i = 1'b1;
        step(3);
        check("full_ready", out_ready_o, 0);
        check("full_level_hold", level_o, 16);
        check("full_stage_valid", in_valid_o, 1);
        check("full_stage_data", in_data_o, 8'h80);
        out_valid_i = 1'b0;
        for (int i = 0; i < 17; i++) exp_q.push_back(8'(8'h80 + i));
        in_ready_i = 1'b1;
        wait_rx(17);
        step(3);
        check_rx("drain");
        check("drain_level", level_o, 0);
        check("hold_violations", hold_bad, 0);

        // COUNT: 300 generated bytes while OUT bytes are swallowed
        mode_i      = 2'b11;
        out_data_i  = 8'h55;
        out_valid_i = 1'b1;
        wait_rx(300);
        in_ready_i = 1'b0;
        check("cnt_ready", out_ready_o, 1);
        check("cnt_level", level_o, 0);
        check("cnt_next", in_data_o, 8'h2C);
        for (int i = 0; i < 300; i++) exp_q.push_back(8'(i));
        check_rx("count");
        out_valid_i = 1'b0;
        mode_i = 2'b00;
        step(3);
        check("cnt_hold_valid", in_valid_o, 1);
        check("cnt_hold_data", in_data_o, 8'h2C);
        in_ready_i = 1'b1;
        step(2);
        push(8'h33);
        exp_q = '{8'h2C, 8'h33};
        wait_rx(2);
        step(3);
        check_rx("cnt_exit");
        // Counter keeps its value across modes
        in_ready_i = 1'b0;
        mode_i = 2'b11;
        step(3);
        check("cnt_resume", in_data_o, 8'h2D);
        mode_i = 2'b00;
        step(2);
        check("cnt_resume_hold", in_data_o, 8'h2D);
        in_ready_i = 1'b1;
        exp_q = '{8'h2D};
        wait_rx(1);
        step(3);
        check_rx("cnt_resume_x");

        // Reset in the middle of a stalled stream
        in_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
        check("mid_level", level_o, 5);
        @(posedge clk);
        #2 rstn_i = 1'b0;
        #1;
        check("mid_rst_ready", out_ready_o, 0);
        check("mid_rst_valid", in_valid_o, 0);
        check("mid_rst_data", in_data_o, 8'h00);
        check("mid_rst_level", level_o, 0);
        @(negedge clk);
        #1 rstn_i = 1'b1;
        step(1);
        check("post_rst_level", level_o, 0);
        rx_q.delete();
        in_ready_i = 1'b1;
        push(8'h77);
        exp_q = '{8'h77};
        wait_rx(1);
        step(3);
        check_rx("post_rst");

        // CR handling
        push(8'h48); push(8'h0D); push(8'h49);
`ifdef APP_CRLF_EN
        exp_q = '{8'h48, 8'h0D, 8'h0A, 8'h49};
`else
        exp_q = '{8'h48, 8'h0D, 8'h49};
`endif
        wait_rx(exp_q.size());
        step(3);
        check_rx("crlf");
        check("final_hold", hold_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
